// File: rtl/ifmap_packet_gen_if.sv
// ifmap_packet_gen_if: valid/ready packet channel between the ifmap packet generator and the PE depacketizer.
interface ifmap_packet_gen_if #(
  parameter int unsigned PKT_W = 49
) ();
  logic             pkt_valid;
  logic             pkt_ready;
  logic [PKT_W-1:0] pkt_data;

  modport master (output pkt_valid, output pkt_data, input pkt_ready);
  modport slave  (input pkt_valid, input pkt_data, output pkt_ready);
endinterface

// File: rtl/ifmap_packet_gen.sv
// ifmap_packet_gen: emits 5 filter-row packets, then ts0/ts1 ifmap window packets per 5x5 location.
// Build macro ZERO_SKIP_EN: locations whose ts0 and ts1 windows are both all-zero are skipped.
module ifmap_packet_gen #(
  parameter int unsigned FILTER_WIDTH = 8,
  parameter int unsigned IFMAP_DIM    = 6,
  parameter int unsigned DEST_NODE    = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flt_wr_en,
  input  logic [2:0]                flt_wr_row,
  input  logic [5*FILTER_WIDTH-1:0] flt_wr_data,
  input  logic                      if_wr_en,
  input  logic                      if_wr_ts,
  input  logic [4:0]                if_wr_row,
  input  logic [IFMAP_DIM-1:0]      if_wr_data,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  ifmap_packet_gen_if.master        pkt
);
  localparam int unsigned DATA_W  = 5 * FILTER_WIDTH;
  localparam int unsigned PKT_W   = 9 + DATA_W;
  localparam int unsigned OUT_DIM = IFMAP_DIM - 4;
  localparam int unsigned IDX_W   = $clog2(IFMAP_DIM);
  localparam logic [IDX_W-1:0] LAST    = IDX_W'(OUT_DIM - 1);
  localparam logic [5:0]       IF_ROWS = 6'(IFMAP_DIM);

  typedef enum logic [1:0] {IDLE, FLT, IFM, FIN} state_t;

  state_t             state, state_n;
  logic [2:0]         flt_row, flt_row_n;
  logic [IDX_W-1:0]   orow, orow_n, ocol, ocol_n;
  logic               ts, ts_n;
  logic [24:0]        win1_q, win1_n;
  logic               valid_n, busy_n, done_n;
  logic [PKT_W-1:0]   data_n;

  logic [DATA_W-1:0]    flt_mem [5];
  logic [IFMAP_DIM-1:0] plane0  [IFMAP_DIM];
  logic [IFMAP_DIM-1:0] plane1  [IFMAP_DIM];

  logic [IDX_W-1:0]  loc_r, loc_c;
  logic              last_loc, first_loc, adv, skip_c;
  logic [24:0]       win0_l, win1_l;
  logic [DATA_W-1:0] row0_c;

  function automatic logic [PKT_W-1:0] flt_pkt(input logic [2:0] r, input logic [DATA_W-1:0] d);
    return {4'(DEST_NODE), 1'b0, 1'b1, r, d};
  endfunction

  function automatic logic [PKT_W-1:0] ifm_pkt(input logic t, input logic [IDX_W-1:0] r,
                                               input logic [IDX_W-1:0] c, input logic [24:0] w);
    return {4'(DEST_NODE), t, 1'b0, 3'b000, DATA_W'({7'(r), 8'(c), w})};
  endfunction

  // Stored filters and ifmap planes; frozen whenever a run is in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      flt_mem <= '{default: '0};
      plane0  <= '{default: '0};
      plane1  <= '{default: '0};
    end else if (state == IDLE) begin
      if (flt_wr_en && flt_wr_row < 3'd5)
        flt_mem[flt_wr_row] <= flt_wr_data;
      if (if_wr_en && {1'b0, if_wr_row} < IF_ROWS) begin
        if (if_wr_ts) plane1[IDX_W'(if_wr_row)] <= if_wr_data;
        else          plane0[IDX_W'(if_wr_row)] <= if_wr_data;
      end
    end
  end

  // Next window location: origin when leaving the filter phase, otherwise row-major successor.
  always_comb begin
    last_loc = (orow == LAST) && (ocol == LAST);
    loc_r    = '0;
    loc_c    = '0;
    if (state == IFM && !last_loc) begin
      if (ocol == LAST) begin
        loc_r = orow + IDX_W'(1);
      end else begin
        loc_r = orow;
        loc_c = ocol + IDX_W'(1);
      end
    end
  end

  always_comb begin
    win0_l = '0;
    win1_l = '0;
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 5; j++) begin
        win0_l[5'(5*i + j)] = plane0[loc_r + IDX_W'(i)][loc_c + IDX_W'(j)];
        win1_l[5'(5*i + j)] = plane1[loc_r + IDX_W'(i)][loc_c + IDX_W'(j)];
      end
    end
  end

`ifdef ZERO_SKIP_EN
  assign skip_c = (win0_l == '0) && (win1_l == '0);
`else
  assign skip_c = 1'b0;
`endif

  // A filter write landing together with start must be visible in the first packet.
  assign row0_c = (flt_wr_en && flt_wr_row == 3'd0) ? flt_wr_data : flt_mem[0];

  always_comb begin
    state_n   = state;
    flt_row_n = flt_row;
    orow_n    = orow;
    ocol_n    = ocol;
    ts_n      = ts;
    win1_n    = win1_q;
    valid_n   = pkt.pkt_valid;
    data_n    = pkt.pkt_data;
    busy_n    = busy;
    done_n    = 1'b0;
    first_loc = 1'b0;
    adv       = 1'b0;

    unique case (state)
      IDLE: begin
        busy_n = 1'b0;
        if (start) begin
          state_n   = FLT;
          flt_row_n = 3'd0;
          valid_n   = 1'b1;
          busy_n    = 1'b1;
          data_n    = flt_pkt(3'd0, row0_c);
        end
      end
      FLT: begin
        if (pkt.pkt_ready) begin
          if (flt_row == 3'd4) begin
            first_loc = 1'b1;
          end else begin
            flt_row_n = flt_row + 3'd1;
            data_n    = flt_pkt(flt_row + 3'd1, flt_mem[flt_row + 3'd1]);
          end
        end
      end
      IFM: begin
        if (!pkt.pkt_valid) begin
          adv = 1'b1;
        end else if (pkt.pkt_ready) begin
          if (!ts) begin
            ts_n   = 1'b1;
            data_n = ifm_pkt(1'b1, orow, ocol, win1_q);
          end else begin
            adv = 1'b1;
          end
        end
      end
      FIN: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
      default: state_n = IDLE;
    endcase

    // Move to the next location, or finish after the final one.
    if (first_loc || adv) begin
      if (adv && last_loc) begin
        state_n = FIN;
        valid_n = 1'b0;
        busy_n  = 1'b0;
        done_n  = 1'b1;
      end else begin
        state_n = IFM;
        orow_n  = loc_r;
        ocol_n  = loc_c;
        ts_n    = 1'b0;
        win1_n  = win1_l;
        if (skip_c) begin
          valid_n = 1'b0;
        end else begin
          valid_n = 1'b1;
          data_n  = ifm_pkt(1'b0, loc_r, loc_c, win0_l);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      flt_row       <= '0;
      orow          <= '0;
      ocol          <= '0;
      ts            <= 1'b0;
      win1_q        <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pkt.pkt_valid <= 1'b0;
      pkt.pkt_data  <= '0;
    end else begin
      state         <= state_n;
      flt_row       <= flt_row_n;
      orow          <= orow_n;
      ocol          <= ocol_n;
      ts            <= ts_n;
      win1_q        <= win1_n;
      busy          <= busy_n;
      done          <= done_n;
      pkt.pkt_valid <= valid_n;
      pkt.pkt_data  <= data_n;
    end
  end
endmodule

// File: tb/tb_ifmap_packet_gen.sv
// tb_ifmap_packet_gen: directed runs against a queue-based packet model built from the stored filters/planes.
module tb_ifmap_packet_gen;
  localparam int unsigned FW    = 8;
  localparam int unsigned DIM   = 6;
  localparam int unsigned OUTD  = DIM - 4;
  localparam int unsigned PKT_W = 9 + 5*FW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flt_wr_en = 1'b0;
  logic [2:0] flt_wr_row = '0;
  logic [5*FW-1:0] flt_wr_data = '0;
  logic if_wr_en = 1'b0;
  logic if_wr_ts = 1'b0;
  logic [4:0] if_wr_row = '0;
  logic [DIM-1:0] if_wr_data = '0;
  logic start = 1'b0;
  logic busy, done;

  ifmap_packet_gen_if #(.PKT_W(PKT_W)) pkt_bus ();

  ifmap_packet_gen #(.FILTER_WIDTH(FW), .IFMAP_DIM(DIM), .DEST_NODE(0)) dut (
    .clk(clk), .rst(rst),
    .flt_wr_en(flt_wr_en), .flt_wr_row(flt_wr_row), .flt_wr_data(flt_wr_data),
    .if_wr_en(if_wr_en), .if_wr_ts(if_wr_ts), .if_wr_row(if_wr_row), .if_wr_data(if_wr_data),
    .start(start), .busy(busy), .done(done), .pkt(pkt_bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc = 0, last_hs = 0, done_cnt = 0;
  bit mon_on = 1'b0, in_run = 1'b0, prev_stall = 1'b0, rdy_mode = 1'b0;
  logic [PKT_W-1:0] prev_data;
  logic [PKT_W-1:0] exp_q[$];
  logic [PKT_W-1:0] got_q[$];
  logic [5*FW-1:0] m_flt [5];
  logic [DIM-1:0]  m_pl  [2][DIM];
  logic [15:0] rdy_pat = 16'b1001_0110_1100_1001;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Expected packet stream straight from the packet rules.
  task automatic build_exp();
    logic [24:0] w0, w1;
    logic [DIM-1:0] rv0, rv1;
    exp_q.delete();
    got_q.delete();
    for (int r = 0; r < 5; r++)
      exp_q.push_back({4'd0, 1'b0, 1'b1, 3'(r), m_flt[3'(r)]});
    for (int orow = 0; orow < OUTD; orow++) begin
      for (int ocol = 0; ocol < OUTD; ocol++) begin
        w0 = '0;
        w1 = '0;
        for (int i = 0; i < 5; i++) begin
          rv0 = m_pl[0][3'(orow + i)];
          rv1 = m_pl[1][3'(orow + i)];
          for (int j = 0; j < 5; j++) begin
            w0[5'(5*i + j)] = rv0[3'(ocol + j)];
            w1[5'(5*i + j)] = rv1[3'(ocol + j)];
          end
        end
`ifdef ZERO_SKIP_EN
        if (w0 == '0 && w1 == '0) continue;
`endif
        exp_q.push_back({4'd0, 1'b0, 1'b0, 3'd0, 7'(orow), 8'(ocol), w0});
        exp_q.push_back({4'd0, 1'b1, 1'b0, 3'd0, 7'(orow), 8'(ocol), w1});
      end
    end
  endtask

  initial begin
    pkt_bus.pkt_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      pkt_bus.pkt_ready = rdy_mode ? rdy_pat[4'(cyc)] : 1'b1;
    end
  end

  // Single compare process: stream order/content, stall stability, busy/done framing.
  always @(negedge clk) begin
    logic [PKT_W-1:0] e;
    cyc++;
    if (mon_on) begin
      if (prev_stall) begin
        chk("stall_valid", 64'(pkt_bus.pkt_valid), 64'(1));
        chk("stall_data", 64'(pkt_bus.pkt_data), 64'(prev_data));
      end
      if (!in_run) chk("idle_valid", 64'(pkt_bus.pkt_valid), 64'(0));
      else chk("busy", 64'(busy), 64'(!done));
      if (pkt_bus.pkt_valid && pkt_bus.pkt_ready) begin
        got_q.push_back(pkt_bus.pkt_data);
        last_hs = cyc;
        if (exp_q.size() == 0) chk("extra_pkt", 64'(pkt_bus.pkt_data), 64'(0));
        else begin
          e = exp_q.pop_front();
          chk("pkt_data", 64'(pkt_bus.pkt_data), 64'(e));
        end
      end
      if (done) begin
        done_cnt++;
        chk("done_in_run", 64'(in_run), 64'(1));
        chk("done_left", 64'(exp_q.size()), 64'(0));
`ifndef ZERO_SKIP_EN
        chk("done_timing", 64'(cyc - last_hs), 64'(1));
`endif
        in_run = 1'b0;
      end
      prev_stall = pkt_bus.pkt_valid && !pkt_bus.pkt_ready;
      prev_data  = pkt_bus.pkt_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic wr_flt(input logic [2:0] r, input logic [5*FW-1:0] d);
    @(posedge clk); #1;
    flt_wr_en = 1'b1; flt_wr_row = r; flt_wr_data = d;
    @(posedge clk); #1;
    flt_wr_en = 1'b0;
  endtask

  task automatic wr_if(input logic t, input logic [4:0] r, input logic [DIM-1:0] d);
    @(posedge clk); #1;
    if_wr_en = 1'b1; if_wr_ts = t; if_wr_row = r; if_wr_data = d;
    @(posedge clk); #1;
    if_wr_en = 1'b0;
  endtask

  task automatic set_plane(input int t, input logic [DIM-1:0] rows [DIM]);
    for (int r = 0; r < DIM; r++) begin
      wr_if(t[0], 5'(r), rows[r]);
      m_pl[t[0]][3'(r)] = rows[r];
    end
  endtask

  task automatic launch(input bit wr, input logic [2:0] r, input logic [5*FW-1:0] d);
    if (wr && r < 3'd5) m_flt[r] = d;
    build_exp();
    @(posedge clk); #1;
    start = 1'b1; flt_wr_en = wr; flt_wr_row = r; flt_wr_data = d;
    @(posedge clk); #1;
    start = 1'b0; flt_wr_en = 1'b0;
    in_run = 1'b1;
  endtask

  task automatic wait_done(input string name);
    int d0 = done_cnt;
    bit ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk);
      if (done_cnt != d0) begin ok = 1'b1; break; end
    end
    chk(name, 64'(ok), 64'(1));
    in_run = 1'b0;
  endtask

  initial begin
    logic [PKT_W-1:0] p;
    logic [DIM-1:0] rows [DIM];
    int n_exp;
    bit ok;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_valid", 64'(pkt_bus.pkt_valid), 64'(0));
    chk("rst_data", 64'(pkt_bus.pkt_data), 64'(0));
    for (int r = 0; r < 5; r++) m_flt[r] = '0;
    for (int r = 0; r < DIM; r++) begin m_pl[0][r] = '0; m_pl[1][r] = '0; end
    mon_on = 1'b1;

    // T1: filters 0x01..0x05, mixed ifmaps, ready held high
    for (int r = 0; r < 5; r++) begin
      wr_flt(3'(r), {5{8'(r + 1)}});
      m_flt[r] = {5{8'(r + 1)}};
    end
    rows = '{6'h2D, 6'h13, 6'h3A, 6'h05, 6'h1C, 6'h27};
    set_plane(0, rows);
    rows = '{6'h15, 6'h2A, 6'h33, 6'h0C, 6'h3F, 6'h21};
    set_plane(1, rows);
    wr_flt(3'd5, {5{8'hFF}});
    wr_if(1'b0, 5'd6, 6'h3F);
    wr_if(1'b1, 5'd9, 6'h3F);
    launch(1'b0, 3'd0, '0);
    wait_done("t1_done");
    chk("t1_count", 64'(got_q.size()), 64'(13));
    chk("t1_first", 64'(got_q[0]), 64'({9'h008, 40'h0101010101}));
    chk("t1_flt4", 64'(got_q[4]), 64'({9'h00C, 40'h0505050505}));
    p = got_q[5];
    chk("t1_loc00_hdr", 64'(p[48:25]), 64'({9'h000, 15'h0000}));
    p = got_q[8];
    chk("t1_loc01_hdr", 64'(p[48:25]), 64'({9'h010, 15'h0001}));
    p = got_q[12];
    chk("t1_loc11_hdr", 64'(p[48:25]), 64'({9'h010, 15'h0101}));

    // T2: identity diagonal vs all-ones at location (1,1)
    for (int r = 0; r < DIM; r++) rows[r] = 6'(1 << r);
    set_plane(0, rows);
    for (int r = 0; r < DIM; r++) rows[r] = 6'h3F;
    set_plane(1, rows);
    launch(1'b0, 3'd0, '0);
    wait_done("t2_done");
    chk("t2_ts0_win", 64'(got_q[11]), 64'({9'h000, 15'h0101, 25'h1041041}));
    chk("t2_ts1_win", 64'(got_q[12]), 64'({9'h010, 15'h0101, 25'h1FFFFFF}));

    // T3: back-pressure pattern, plus a row-0 filter write in the start cycle
    rdy_mode = 1'b1;
    launch(1'b1, 3'd0, {5{8'hA5}});
    wait_done("t3_done");
    rdy_mode = 1'b0;
    chk("t3_count", 64'(got_q.size()), 64'(13));
    chk("t3_row0", 64'(got_q[0]), 64'({9'h008, {5{8'hA5}}}));

    // T5: start and writes while busy are ignored; stored data survives
    launch(1'b0, 3'd0, '0);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1; if_wr_en = 1'b1; if_wr_ts = 1'b0; if_wr_row = 5'd0; if_wr_data = 6'h3E;
    flt_wr_en = 1'b1; flt_wr_row = 3'd1; flt_wr_data = {5{8'hFF}};
    @(posedge clk); #1;
    start = 1'b0; if_wr_en = 1'b0; flt_wr_en = 1'b0;
    wait_done("t5_done");
    chk("t5_count", 64'(got_q.size()), 64'(13));
    launch(1'b0, 3'd0, '0);
    wait_done("t5_rerun_done");
    chk("t5_rerun_count", 64'(got_q.size()), 64'(13));
    chk("t5_rerun_flt1", 64'(got_q[1]), 64'({9'h009, 40'h0202020202}));

    // T4: reset mid-IFM aborts without done; next run sees zeroed storage
    launch(1'b0, 3'd0, '0);
    ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk);
      if (got_q.size() >= 8) begin ok = 1'b1; break; end
    end
    chk("t4_reach_ifm", 64'(ok), 64'(1));
    #1;
    mon_on = 1'b0; in_run = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t4_valid", 64'(pkt_bus.pkt_valid), 64'(0));
    chk("t4_busy", 64'(busy), 64'(0));
    chk("t4_data", 64'(pkt_bus.pkt_data), 64'(0));
    for (int k = 0; k < 6; k++) begin
      chk("t4_no_done", 64'(done), 64'(0));
      @(negedge clk);
    end
    for (int r = 0; r < 5; r++) m_flt[r] = '0;
    for (int r = 0; r < DIM; r++) begin m_pl[0][r] = '0; m_pl[1][r] = '0; end
    mon_on = 1'b1;
    launch(1'b0, 3'd0, '0);
    wait_done("t4_rerun_done");
`ifdef ZERO_SKIP_EN
    n_exp = 5;
`else
    n_exp = 13;
`endif
    chk("t4_rerun_count", 64'(got_q.size()), 64'(n_exp));
    chk("t4_rerun_flt0", 64'(got_q[0]), 64'({9'h008, 40'h0}));

`ifdef ZERO_SKIP_EN
    // T6: only plane1 row 0 set, so every orow=1 location is skipped
    wr_if(1'b1, 5'd0, 6'h3F);
    m_pl[1][0] = 6'h3F;
    launch(1'b0, 3'd0, '0);
    wait_done("t6_done");
    chk("t6_count", 64'(got_q.size()), 64'(9));
`endif

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end
endmodule
